// File: rtl/gear_adder_pipe.sv
// Two-stage GeAr-style approximate adder: low ke bits approximated (XOR/OR, no carry), upper bits exact.
// Optional error statistics ports are enabled with the GEAR_ERR_STATS_EN macro.
module gear_adder_pipe #(
  parameter int WIDTH       = 16,
  parameter int APPROX_BITS = 4,
  parameter int KW          = $clog2(APPROX_BITS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_mode,
  input  logic [KW-1:0]    in_k,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef GEAR_ERR_STATS_EN
  input  logic                   stats_clr,
  output logic [APPROX_BITS:0]   err_dist,
  output logic [31:0]            err_count,
  output logic [APPROX_BITS:0]   err_max,
`endif
  output logic [WIDTH:0]   out_sum
);

  localparam int SW = WIDTH + 1;
  localparam logic [KW-1:0] K_MAX = KW'(APPROX_BITS);

  // Handshake: a beat moves on valid && ready. A stage may load when it is empty or its
  // downstream stage is advancing, so in_ready never depends combinationally on in_valid.
  logic adv1, adv2, in_xfer;

  logic                   s1_valid_q, s1_valid_d;
  logic [APPROX_BITS-1:0] s1_lo_q, s1_lo_d;
  logic [WIDTH-1:0]       s1_a_hi_q, s1_a_hi_d;
  logic [WIDTH-1:0]       s1_b_hi_q, s1_b_hi_d;
  logic [KW-1:0]          s1_ke_q, s1_ke_d;
  logic                   s2_valid_q, s2_valid_d;
  logic [WIDTH:0]         out_sum_q, out_sum_d;

  logic [KW-1:0]          k_clamp, ke;
  logic [APPROX_BITS-1:0] lo_mask, lo_raw;
  logic [WIDTH:0]         hi_sum, approx;

  always_comb begin
    adv2    = !s2_valid_q || out_ready;
    adv1    = !s1_valid_q || adv2;
    in_xfer = in_valid && adv1;

    k_clamp = (in_k > K_MAX) ? K_MAX : in_k;
    ke      = (in_mode == 2'b01 || in_mode == 2'b10) ? k_clamp : '0;
    lo_mask = ~({APPROX_BITS{1'b1}} << ke);
    lo_raw  = (in_mode == 2'b01) ? (in_a[APPROX_BITS-1:0] ^ in_b[APPROX_BITS-1:0])
                                 : (in_a[APPROX_BITS-1:0] | in_b[APPROX_BITS-1:0]);

    s1_valid_d = adv1 ? in_valid : s1_valid_q;
    s1_lo_d    = s1_lo_q;
    s1_a_hi_d  = s1_a_hi_q;
    s1_b_hi_d  = s1_b_hi_q;
    s1_ke_d    = s1_ke_q;
    if (in_xfer) begin
      s1_lo_d   = lo_raw & lo_mask;
      s1_a_hi_d = in_a >> ke;
      s1_b_hi_d = in_b >> ke;
      s1_ke_d   = ke;
    end

    // Upper part is added with zero carry-in; the low part is simply OR-ed below it.
    hi_sum = {1'b0, s1_a_hi_q} + {1'b0, s1_b_hi_q};
    approx = (hi_sum << s1_ke_q) | {{(SW - APPROX_BITS){1'b0}}, s1_lo_q};

    s2_valid_d = adv2 ? s1_valid_q : s2_valid_q;
    out_sum_d  = (adv2 && s1_valid_q) ? approx : out_sum_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_lo_q    <= '0;
      s1_a_hi_q  <= '0;
      s1_b_hi_q  <= '0;
      s1_ke_q    <= '0;
      s2_valid_q <= 1'b0;
      out_sum_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_lo_q    <= s1_lo_d;
      s1_a_hi_q  <= s1_a_hi_d;
      s1_b_hi_q  <= s1_b_hi_d;
      s1_ke_q    <= s1_ke_d;
      s2_valid_q <= s2_valid_d;
      out_sum_q  <= out_sum_d;
    end
  end

  assign in_ready  = adv1;
  assign out_valid = s2_valid_q;
  assign out_sum   = out_sum_q;

`ifdef GEAR_ERR_STATS_EN
  // Error is (a_lo + b_lo) - lo: the upper parts cancel between exact and approximate sums.
  logic [APPROX_BITS-1:0] s1_a_lo_q, s1_a_lo_d;
  logic [APPROX_BITS-1:0] s1_b_lo_q, s1_b_lo_d;
  logic [APPROX_BITS:0]   err_dist_q, err_dist_d;
  logic [31:0]            err_count_q, err_count_d;
  logic [APPROX_BITS:0]   err_max_q, err_max_d;
  logic [APPROX_BITS:0]   err_now;

  always_comb begin
    s1_a_lo_d = in_xfer ? (in_a[APPROX_BITS-1:0] & lo_mask) : s1_a_lo_q;
    s1_b_lo_d = in_xfer ? (in_b[APPROX_BITS-1:0] & lo_mask) : s1_b_lo_q;
    err_now   = {1'b0, s1_a_lo_q} + {1'b0, s1_b_lo_q} - {1'b0, s1_lo_q};
    err_dist_d = (adv2 && s1_valid_q) ? err_now : err_dist_q;

    err_count_d = err_count_q;
    err_max_d   = err_max_q;
    if (stats_clr) begin
      err_count_d = '0;
      err_max_d   = '0;
    end else if (s2_valid_q && out_ready) begin
      if (err_dist_q != '0 && err_count_q != 32'hFFFF_FFFF) err_count_d = err_count_q + 32'd1;
      if (err_dist_q > err_max_q) err_max_d = err_dist_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_a_lo_q   <= '0;
      s1_b_lo_q   <= '0;
      err_dist_q  <= '0;
      err_count_q <= '0;
      err_max_q   <= '0;
    end else begin
      s1_a_lo_q   <= s1_a_lo_d;
      s1_b_lo_q   <= s1_b_lo_d;
      err_dist_q  <= err_dist_d;
      err_count_q <= err_count_d;
      err_max_q   <= err_max_d;
    end
  end

  assign err_dist  = err_dist_q;
  assign err_count = err_count_q;
  assign err_max   = err_max_q;
`endif

endmodule

// File: tb/tb_gear_adder_pipe.sv
// Self-checking bench for gear_adder_pipe (WIDTH=8, APPROX_BITS=4): directed cases, stall,
// reset-in-flight and randomized traffic compared against an arithmetic reference model.
module tb_gear_adder_pipe;

  localparam int W  = 8;
  localparam int AB = 4;
  localparam int KW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;
  logic [1:0]    in_mode = '0;
  logic [KW-1:0] in_k = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W:0]    out_sum;
`ifdef GEAR_ERR_STATS_EN
  logic          stats_clr = 1'b0;
  logic [AB:0]   err_dist;
  logic [31:0]   err_count;
  logic [AB:0]   err_max;
`endif

  gear_adder_pipe #(.WIDTH(W), .APPROX_BITS(AB)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .in_k(in_k),
    .out_valid(out_valid), .out_ready(out_ready),
`ifdef GEAR_ERR_STATS_EN
    .stats_clr(stats_clr), .err_dist(err_dist), .err_count(err_count), .err_max(err_max),
`endif
    .out_sum(out_sum)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int stall_cycles = 0;
  bit rand_ready_en = 1'b0;
  logic [W:0]  exp_q[$];
  logic [AB:0] err_q[$];
  bit          prev_stall = 1'b0;
  logic [W:0]  prev_sum;
  int          m_count = 0;
  int          m_max = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: upper parts added exactly, low ke bits from a per-bit XOR/OR, carry dropped.
  function automatic void model(input int a, input int b, input int mode, input int k,
                                output logic [W:0] s, output logic [AB:0] e);
    int ke, lo, ap, ex;
    ke = (mode == 1 || mode == 2) ? ((k > AB) ? AB : k) : 0;
    lo = 0;
    for (int i = 0; i < ke; i++) begin
      int ba, bb;
      ba = (a >> i) & 1;
      bb = (b >> i) & 1;
      lo += ((mode == 1) ? (ba ^ bb) : (ba | bb)) << i;
    end
    ap = (((a >> ke) + (b >> ke)) << ke) + lo;
    ex = a + b;
    s = ap[W:0];
    e = AB'(ex - ap) + (AB+1)'(0);
    e = (AB+1)'(ex - ap);
  endfunction

  // ---------------- monitor / compare ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
      m_count = 0;
      m_max = 0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_sum", 32'(out_sum), 32'(prev_sum));
      end
      prev_stall = out_valid && !out_ready;
      prev_sum = out_sum;
`ifdef GEAR_ERR_STATS_EN
      check("err_count", err_count, 32'(m_count));
      check("err_max", 32'(err_max), 32'(m_max));
`endif
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 32'd1, 32'd0);
        end else begin
          logic [W:0]  es;
          logic [AB:0] ee;
          es = exp_q.pop_front();
          ee = err_q.pop_front();
          check("out_sum", 32'(out_sum), 32'(es));
`ifdef GEAR_ERR_STATS_EN
          check("err_dist", 32'(err_dist), 32'(ee));
          if (!stats_clr) begin
            if (ee != 0) m_count++;
            if (int'(ee) > m_max) m_max = int'(ee);
          end
`endif
        end
      end
`ifdef GEAR_ERR_STATS_EN
      if (stats_clr) begin
        m_count = 0;
        m_max = 0;
      end
`endif
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_ready_en) out_ready = ($urandom_range(0, 3) != 0);
  end

  // ---------------- driver ----------------
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] mode,
                      input logic [KW-1:0] k, input logic [W:0] es, input logic [AB:0] ee);
    bit done = 1'b0;
    int waits = 0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_mode = mode;
    in_k = k;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(es);
        err_q.push_back(ee);
        done = 1'b1;
      end else begin
        stall_cycles++;
      end
      @(posedge clk);
      #1;
      if (!done && ++waits > 1000) begin
        check("send_timeout", 32'd1, 32'd0);
        done = 1'b1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic send_rand();
    logic [W-1:0]  a, b;
    logic [1:0]    mode;
    logic [KW-1:0] k;
    logic [W:0]    s;
    logic [AB:0]   e;
    a = W'($urandom_range(0, 255));
    b = W'($urandom_range(0, 255));
    mode = 2'($urandom_range(0, 3));
    k = KW'($urandom_range(0, 7));
    model(int'(a), int'(b), int'(mode), int'(k), s, e);
    send(a, b, mode, k, s, e);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W:0]  ms;
    logic [AB:0] me;

    // model pinned against hand-computed values
    model(8'h0F, 8'h01, 1, 4, ms, me);
    check("model_xor", 32'(ms), 32'h00E);
    model(8'hFF, 8'hFF, 1, 7, ms, me);
    check("model_clamp_err", 32'(me), 32'h1E);
    model(8'h0F, 8'h01, 2, 4, ms, me);
    check("model_or", 32'(ms), 32'h00F);

    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sum", 32'(out_sum), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;

    // directed cases from hand computation
    send(8'h0F, 8'h01, 2'b01, 3'd4, 9'h00E, 5'd2);
    send(8'h0F, 8'h01, 2'b10, 3'd4, 9'h00F, 5'd1);
    send(8'h0F, 8'h01, 2'b00, 3'd4, 9'h010, 5'd0);
    send(8'h0F, 8'h01, 2'b11, 3'd4, 9'h010, 5'd0);
    send(8'hFF, 8'hFF, 2'b01, 3'd4, 9'h1E0, 5'h1E);
    send(8'hFF, 8'hFF, 2'b01, 3'd0, 9'h1FE, 5'd0);
    send(8'hFF, 8'hFF, 2'b01, 3'd7, 9'h1E0, 5'h1E);
    wait_drain("directed_drain");

    // 20 back-to-back beats: no stalls, everything drained right after the last one
    stall_cycles = 0;
    for (int i = 0; i < 20; i++) send_rand();
    check("b2b_stalls", 32'(stall_cycles), 32'd0);
    @(posedge clk);
    @(negedge clk);
    #1;
    check("b2b_no_bubble", 32'(exp_q.size()), 32'd0);

    // stall: both stages fill, in_ready drops, output held
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send_rand();
    send_rand();
    check("stall_in_ready", 32'(in_ready), 32'd0);
    check("stall_out_valid", 32'(out_valid), 32'd1);
    repeat (5) @(posedge clk);
    #1;
    out_ready = 1'b1;
    send_rand();
    wait_drain("stall_drain");

    // reset with two beats in flight
    out_ready = 1'b0;
    send_rand();
    send_rand();
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out_sum", 32'(out_sum), 32'd0);
`ifdef GEAR_ERR_STATS_EN
    check("mid_rst_err_count", err_count, 32'd0);
    check("mid_rst_err_max", 32'(err_max), 32'd0);
`endif
    exp_q.delete();
    err_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    send(8'h0F, 8'h01, 2'b01, 3'd4, 9'h00E, 5'd2);
    check("lat_cycle1", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    check("lat_cycle2", 32'(out_valid), 32'd1);
    check("lat_sum", 32'(out_sum), 32'h00E);
    wait_drain("lat_drain");

`ifdef GEAR_ERR_STATS_EN
    // clear pulsed on an erroneous output transfer: the clear wins
    send(8'hFF, 8'hFF, 2'b01, 3'd4, 9'h1E0, 5'h1E);
    send(8'h0F, 8'h01, 2'b01, 3'd4, 9'h00E, 5'd2);
    @(posedge clk);
    #1;
    stats_clr = 1'b1;
    @(posedge clk);
    #1;
    stats_clr = 1'b0;
    check("clr_err_count", err_count, 32'd0);
    check("clr_err_max", 32'(err_max), 32'd0);
    wait_drain("clr_drain");
`endif

    // randomized traffic with random back-pressure and input gaps
    rand_ready_en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      send_rand();
    end
    rand_ready_en = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    wait_drain("rand_drain");

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
